// File: rtl/fetch_stage.sv
// fetch_stage: PC + 4-line direct-mapped icache with refill FSM; FETCH_PERF_CNT_EN adds miss_count.
module fetch_stage #(
    parameter int VIRT_ADDR_WIDTH   = 32,
    parameter int ICACHE_LINE_WIDTH = 128,
    parameter int MEM_ADDRESS_LEN   = 20,
    parameter int ICACHE_LINES      = 4,
    parameter logic [VIRT_ADDR_WIDTH-1:0] RESET_PC = 32'h0000_1000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [VIRT_ADDR_WIDTH-1:0]   PCbranch,
    input  logic                         branch_hit,
    input  logic                         wrt_en,
    input  logic [ICACHE_LINE_WIDTH-1:0] instr_from_mem,
    input  logic                         mem_data_rdy,
    input  logic                         data_filled_ack,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]                  miss_count,
`endif
    output logic [VIRT_ADDR_WIDTH-1:0]   PCnext,
    output logic [VIRT_ADDR_WIDTH-1:0]   instruction,
    output logic                         reqI_mem,
    output logic [MEM_ADDRESS_LEN-1:0]   reqAddrI_mem
);
    localparam int OFF_W = $clog2(ICACHE_LINE_WIDTH / 8);
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = VIRT_ADDR_WIDTH - OFF_W - IDX_W;

    typedef enum logic [1:0] {RUN, MISS, ACK} state_t;

    state_t                         state, state_nxt;
    logic [VIRT_ADDR_WIDTH-1:0]     pc, pc_nxt;
    logic [ICACHE_LINES-1:0]        valid;
    logic [TAG_W-1:0]               tags  [ICACHE_LINES];
    logic [ICACHE_LINE_WIDTH-1:0]   lines [ICACHE_LINES];
    logic [TAG_W-1:0]               fill_tag;
    logic [IDX_W-1:0]               idx, fill_idx;
    logic [TAG_W-1:0]               tag;
    logic                           hit, redirect, fill, start_miss;

    assign idx        = pc[OFF_W +: IDX_W];
    assign tag        = pc[VIRT_ADDR_WIDTH-1 -: TAG_W];
    assign fill_idx   = reqAddrI_mem[OFF_W +: IDX_W];
    assign hit        = valid[idx] && tags[idx] == tag;
    assign redirect   = wrt_en && branch_hit;
    assign fill       = state == MISS && mem_data_rdy;
    assign start_miss = state == RUN && state_nxt == MISS;
    assign PCnext     = pc + 32'd4;
    assign reqI_mem   = state == MISS;
    assign instruction = (state == RUN && hit) ? lines[idx][{pc[OFF_W-1:2], 5'b0} +: 32] : '0;

    // A redirect in RUN suppresses the miss so the abandoned PC never requests.
    always_comb begin
        pc_nxt    = redirect ? (PCbranch & ~32'd3) : (state == RUN && wrt_en && hit) ? PCnext : pc;
        state_nxt = state;
        if (state == RUN)
            state_nxt = (hit || redirect) ? RUN : MISS;
        else if (fill)
            state_nxt = data_filled_ack ? RUN : ACK;
        else if (state == ACK && data_filled_ack)
            state_nxt = RUN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            pc           <= RESET_PC;
            valid        <= '0;
            reqAddrI_mem <= '0;
            fill_tag     <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (start_miss) begin
                reqAddrI_mem <= {pc[MEM_ADDRESS_LEN-1:OFF_W], {OFF_W{1'b0}}};
                fill_tag     <= tag;
            end
            if (fill)
                valid[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            lines[fill_idx] <= instr_from_mem;
            tags[fill_idx]  <= fill_tag;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            miss_count <= '0;
        else if (start_miss && miss_count != 16'hFFFF)
            miss_count <= miss_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
module tb_fetch_stage;
    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  PCbranch;
    logic         branch_hit, wrt_en, mem_data_rdy, data_filled_ack;
    logic [127:0] instr_from_mem;
    logic [31:0]  PCnext, instruction;
    logic         reqI_mem;
    logic [19:0]  reqAddrI_mem;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]  miss_count;
`endif
    int n_chk = 0;
    int n_fail = 0;

    localparam logic [127:0] LINE_A = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    localparam logic [127:0] LINE_B = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
    localparam logic [127:0] LINE_C = 128'h8888_8888_7777_7777_6666_6666_5555_5555;

    fetch_stage dut (
        .clk(clk), .reset(reset), .PCbranch(PCbranch), .branch_hit(branch_hit),
        .wrt_en(wrt_en), .instr_from_mem(instr_from_mem), .mem_data_rdy(mem_data_rdy),
        .data_filled_ack(data_filled_ack),
`ifdef FETCH_PERF_CNT_EN
        .miss_count(miss_count),
`endif
        .PCnext(PCnext), .instruction(instruction), .reqI_mem(reqI_mem),
        .reqAddrI_mem(reqAddrI_mem)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; PCbranch = 32'h10; branch_hit = 1'b0; wrt_en = 1'b1;
        mem_data_rdy = 1'b0; data_filled_ack = 1'b0; instr_from_mem = '0;
        step; step;
        n_chk++; if (PCnext !== 32'h1004) begin n_fail++; $display("FAIL reset_pcnext: got %h want %h", PCnext, 32'h1004); end
        n_chk++; if (reqI_mem !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", reqI_mem); end
        n_chk++; if (instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instruction); end
        n_chk++; if (reqAddrI_mem !== 20'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", reqAddrI_mem); end
    endtask

    task automatic test_cold_miss;
        logic [31:0] exp_w [4];
        exp_w = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        reset = 1'b0;
        step;
        n_chk++; if (reqI_mem !== 1'b1) begin n_fail++; $display("FAIL cold_req: got %b want 1", reqI_mem); end
        n_chk++; if (reqAddrI_mem !== 20'h01000) begin n_fail++; $display("FAIL cold_addr: got %h want %h", reqAddrI_mem, 20'h01000); end
        n_chk++; if (instruction !== 32'h0) begin n_fail++; $display("FAIL cold_bubble: got %h want 0", instruction); end
        instr_from_mem = LINE_A; mem_data_rdy = 1'b1;
        step;
        mem_data_rdy = 1'b0; data_filled_ack = 1'b1;
        #1;
        n_chk++; if (reqI_mem !== 1'b0) begin n_fail++; $display("FAIL ack_req: got %b want 0", reqI_mem); end
        n_chk++; if (instruction !== 32'h0) begin n_fail++; $display("FAIL ack_bubble: got %h want 0", instruction); end
        step;
        data_filled_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_chk++; if (instruction !== exp_w[i]) begin n_fail++; $display("FAIL cold_word%0d: got %h want %h", i, instruction, exp_w[i]); end
            n_chk++; if (PCnext !== 32'h1004 + 32'(4 * i)) begin n_fail++; $display("FAIL cold_pcnext%0d: got %h want %h", i, PCnext, 32'h1004 + 32'(4 * i)); end
            if (i < 3) step;
        end
    endtask

    task automatic test_branch;
        branch_hit = 1'b1; PCbranch = 32'h100B;
        step;
        n_chk++; if (instruction !== 32'h33333333) begin n_fail++; $display("FAIL br_word: got %h want %h", instruction, 32'h33333333); end
        n_chk++; if (PCnext !== 32'h100C) begin n_fail++; $display("FAIL br_pcnext: got %h want %h", PCnext, 32'h100C); end
        PCbranch = 32'h10;
        step;
        branch_hit = 1'b0;
        #1;
        n_chk++; if (instruction !== 32'h0 || reqI_mem !== 1'b0) begin n_fail++; $display("FAIL br_miss_run: got instr %h req %b want 0 0", instruction, reqI_mem); end
        step;
        n_chk++; if (reqI_mem !== 1'b1 || reqAddrI_mem !== 20'h00010) begin n_fail++; $display("FAIL br_req: got req %b addr %h want 1 %h", reqI_mem, reqAddrI_mem, 20'h00010); end
        instr_from_mem = LINE_B; mem_data_rdy = 1'b1; data_filled_ack = 1'b1;
        step;
        mem_data_rdy = 1'b0; data_filled_ack = 1'b0;
        #1;
        n_chk++; if (reqI_mem !== 1'b0 || instruction !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL direct_run: got req %b instr %h want 0 %h", reqI_mem, instruction, 32'hAAAAAAAA); end
    endtask

    task automatic test_stall;
        wrt_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step;
            n_chk++; if (instruction !== 32'hAAAAAAAA || PCnext !== 32'h14) begin n_fail++; $display("FAIL stall%0d: got instr %h pcnext %h want %h %h", i, instruction, PCnext, 32'hAAAAAAAA, 32'h14); end
        end
        wrt_en = 1'b1;
        step;
        n_chk++; if (instruction !== 32'hBBBBBBBB || PCnext !== 32'h18) begin n_fail++; $display("FAIL unstall: got instr %h pcnext %h want %h %h", instruction, PCnext, 32'hBBBBBBBB, 32'h18); end
    endtask

    task automatic test_conflict;
        branch_hit = 1'b1; PCbranch = 32'h1000;
        step;
        n_chk++; if (instruction !== 32'h11111111) begin n_fail++; $display("FAIL cf_first: got %h want %h", instruction, 32'h11111111); end
        PCbranch = 32'h1040;
        step;
        branch_hit = 1'b0;
        #1;
        n_chk++; if (instruction !== 32'h0) begin n_fail++; $display("FAIL cf_miss: got %h want 0", instruction); end
        step;
        n_chk++; if (reqI_mem !== 1'b1 || reqAddrI_mem !== 20'h01040) begin n_fail++; $display("FAIL cf_req: got req %b addr %h want 1 %h", reqI_mem, reqAddrI_mem, 20'h01040); end
        instr_from_mem = LINE_C; mem_data_rdy = 1'b1;
        step;
        mem_data_rdy = 1'b0; data_filled_ack = 1'b1;
        step;
        data_filled_ack = 1'b0;
        #1;
        n_chk++; if (instruction !== 32'h55555555) begin n_fail++; $display("FAIL cf_fill: got %h want %h", instruction, 32'h55555555); end
        branch_hit = 1'b1; PCbranch = 32'h1000;
        step;
        branch_hit = 1'b0;
        #1;
        n_chk++; if (instruction !== 32'h0) begin n_fail++; $display("FAIL cf_back_miss: got %h want 0", instruction); end
        step;
        n_chk++; if (reqI_mem !== 1'b1 || reqAddrI_mem !== 20'h01000) begin n_fail++; $display("FAIL cf_back_req: got req %b addr %h want 1 %h", reqI_mem, reqAddrI_mem, 20'h01000); end
        // redirect while MISS: fill still lands in the line latched at request time
        branch_hit = 1'b1; PCbranch = 32'h10; instr_from_mem = LINE_A; mem_data_rdy = 1'b1; data_filled_ack = 1'b1;
        step;
        branch_hit = 1'b0; mem_data_rdy = 1'b0; data_filled_ack = 1'b0;
        #1;
        n_chk++; if (reqI_mem !== 1'b0 || instruction !== 32'hAAAAAAAA || PCnext !== 32'h14) begin n_fail++; $display("FAIL miss_redirect: got req %b instr %h pcnext %h want 0 %h %h", reqI_mem, instruction, PCnext, 32'hAAAAAAAA, 32'h14); end
        branch_hit = 1'b1; PCbranch = 32'h1000;
        step;
        branch_hit = 1'b0;
        #1;
        n_chk++; if (instruction !== 32'h11111111) begin n_fail++; $display("FAIL latched_fill: got %h want %h", instruction, 32'h11111111); end
    endtask

    task automatic test_reset_mid_miss;
        branch_hit = 1'b1; PCbranch = 32'h1040;
        step;
        branch_hit = 1'b0;
        step;
        n_chk++; if (reqI_mem !== 1'b1) begin n_fail++; $display("FAIL rm_req: got %b want 1", reqI_mem); end
        reset = 1'b1;
        #1;
        n_chk++; if (reqI_mem !== 1'b0 || PCnext !== 32'h1004 || reqAddrI_mem !== 20'h0) begin n_fail++; $display("FAIL rm_async: got req %b pcnext %h addr %h want 0 %h 0", reqI_mem, PCnext, reqAddrI_mem, 32'h1004); end
        step;
        reset = 1'b0;
        #1;
        n_chk++; if (instruction !== 32'h0) begin n_fail++; $display("FAIL rm_invalid: got %h want 0", instruction); end
        step;
        n_chk++; if (reqI_mem !== 1'b1 || reqAddrI_mem !== 20'h01000) begin n_fail++; $display("FAIL rm_refetch: got req %b addr %h want 1 %h", reqI_mem, reqAddrI_mem, 20'h01000); end
`ifdef FETCH_PERF_CNT_EN
        n_chk++; if (miss_count !== 16'd1) begin n_fail++; $display("FAIL miss_count: got %0d want 1", miss_count); end
`endif
    endtask

    initial begin
        test_reset;
        test_cold_miss;
        test_branch;
        test_stall;
        test_conflict;
        test_reset_mid_miss;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
